// File: rtl/pixel_write_engine.sv
// ---------------------------------------------------------------------------
// pixel_write_engine
//
// Framebuffer write stage fed by the addressing engine. Each accepted command
// names one 12-bit pixel inside an 8-pixel group that is packed into three
// consecutive 32-bit words (96 bits). The engine read-modify-writes the one
// or two words that hold the pixel and then reopens the handshake.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_         asynchronous active-low reset
//   init_addr    word address of word 0 of the pixel group
//   addr_offset  pixel index k within the group (0-7)
//   in_color     12-bit pixel colour
//   in_rts       upstream has a command
//   in_rtr       engine can take a command (transfer = in_rts & in_rtr)
//   mem_en       memory request valid
//   mem_we       1 = write, 0 = read
//   mem_addr     request word address
//   mem_wdata    write data
//   mem_gnt      arbiter grant; request taken when mem_en & mem_gnt
//   mem_rdata    read data, valid the cycle after an accepted read
//   done         one-cycle pulse after the final write of a pixel
// ---------------------------------------------------------------------------
module pixel_write_engine (
  input  logic        clk,
  input  logic        rst_,
  input  logic [16:0] init_addr,
  input  logic [2:0]  addr_offset,
  input  logic [11:0] in_color,
  input  logic        in_rts,
  output logic        in_rtr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  k_q;
  logic [11:0] color_q;
  logic        two_word_q;
  logic        word_idx_q;

  // Index (0..2) of the first group word touched by pixel k.
  function automatic logic [1:0] first_word(input logic [2:0] k);
    if (k < 3'd3)      return 2'd0;
    else if (k < 3'd6) return 2'd1;
    else               return 2'd2;
  endfunction

  // Merge: place the colour at bit 12k of the 96-bit group, then pick out
  // the 32-bit slice for the word currently being processed. Pixels that
  // straddle a word boundary simply contribute part of their field to each
  // of the two slices.
  logic [6:0]  shift;
  logic [95:0] grp_mask;
  logic [95:0] grp_data;
  logic [1:0]  grp_word;
  logic [31:0] word_mask;
  logic [31:0] word_data;
  logic [31:0] merged;

  always_comb begin
    shift     = {4'd0, k_q} * 7'd12;
    grp_mask  = {84'd0, 12'hFFF} << shift;
    grp_data  = {84'd0, color_q} << shift;
    grp_word  = first_word(k_q) + {1'b0, word_idx_q};
    word_mask = 32'd0;
    word_data = 32'd0;
    case (grp_word)
      2'd0: begin
        word_mask = grp_mask[31:0];
        word_data = grp_data[31:0];
      end
      2'd1: begin
        word_mask = grp_mask[63:32];
        word_data = grp_data[63:32];
      end
      default: begin
        word_mask = grp_mask[95:64];
        word_data = grp_data[95:64];
      end
    endcase
    merged = (mem_rdata & ~word_mask) | (word_data & word_mask);
  end

  // Control FSM. All memory-side outputs are registered so they stay put
  // while the arbiter withholds the grant. mem_rdata is only looked at in
  // WAIT, which is always the cycle right after the read was accepted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      in_rtr     <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 17'd0;
      mem_wdata  <= 32'd0;
      done       <= 1'b0;
      k_q        <= 3'd0;
      color_q    <= 12'd0;
      two_word_q <= 1'b0;
      word_idx_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_rts) begin
            k_q        <= addr_offset;
            color_q    <= in_color;
            two_word_q <= (addr_offset == 3'd2) || (addr_offset == 3'd5);
            word_idx_q <= 1'b0;
            mem_addr   <= init_addr + {15'd0, first_word(addr_offset)};
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            in_rtr     <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          if (mem_gnt) begin
            mem_en <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          mem_wdata <= merged;
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          if (mem_gnt) begin
            if (two_word_q && !word_idx_q) begin
              // Second half of a split pixel lives in the next word.
              word_idx_q <= 1'b1;
              mem_addr   <= mem_addr + 17'd1;
              mem_we     <= 1'b0;
              state      <= READ;
            end else begin
              mem_en <= 1'b0;
              mem_we <= 1'b0;
              in_rtr <= 1'b1;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_engine.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_engine
//
// Drives pixel commands into pixel_write_engine, backs it with a small word
// memory, and compares the memory contents and handshake timing against a
// pixel-level reference that treats each group as a flat 96-bit vector.
// ---------------------------------------------------------------------------
module tb_pixel_write_engine;

  logic        clk = 1'b0;
  logic        rst_;
  logic [16:0] init_addr;
  logic [2:0]  addr_offset;
  logic [11:0] in_color;
  logic        in_rts;
  logic        in_rtr;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int rd_cycles[$];
  int wr_cycles[$];

  logic rand_gnt  = 1'b0;
  logic gnt_force = 1'b1;
  logic gnt_rand  = 1'b1;

  assign mem_gnt = rand_gnt ? gnt_rand : gnt_force;

  pixel_write_engine dut (
    .clk         (clk),
    .rst_        (rst_),
    .init_addr   (init_addr),
    .addr_offset (addr_offset),
    .in_color    (in_color),
    .in_rts      (in_rts),
    .in_rtr      (in_rtr),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rdata   (mem_rdata),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Random grant pattern, changed away from the active edge.
  always @(negedge clk) gnt_rand = ($urandom_range(0, 3) != 0);

  // Memory responder: writes land on the accepting edge, read data shows up
  // for exactly one cycle after an accepted read and is junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_gnt && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cycles.push_back(cyc);
    end
    if (mem_en && mem_gnt && !mem_we) begin
      mem_rdata <= mem[mem_addr[7:0]];
      rd_cycles.push_back(cyc);
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Reference: the group is one 96-bit vector, pixel k sits at bit 12k.
  function automatic void ref_write(input int a, input int k, input logic [11:0] c);
    logic [95:0] g;
    g = {ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    g[12*k +: 12] = c;
    ref_mem[a]   = g[31:0];
    ref_mem[a+1] = g[63:32];
    ref_mem[a+2] = g[95:64];
  endfunction

  task automatic preload(input int a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic clear_log();
    rd_cycles.delete();
    wr_cycles.delete();
  endtask

  // Present a command, wait for the transfer, then scramble the fields to
  // show they are not looked at afterwards. Returns the transfer cycle, or
  // -1 if in_rtr never rose. Ends at the negedge after the transfer.
  task automatic send_cmd(input int a, input int k, input logic [11:0] c, output int t);
    int n;
    @(negedge clk);
    init_addr   = 17'(a);
    addr_offset = 3'(k);
    in_color    = c;
    in_rts      = 1'b1;
    n = 0;
    while (!in_rtr && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = in_rtr ? cyc : -1;
    @(negedge clk);
    in_rts      = 1'b0;
    init_addr   = 17'($urandom);
    addr_offset = 3'($urandom);
    in_color    = 12'($urandom);
  endtask

  // Returns the cycle in which done is seen high, or -1 on timeout.
  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic applyStimulus();
  endtask

  task automatic test_reset();
    rst_        = 1'b0;
    in_rts      = 1'b0;
    init_addr   = 17'd0;
    addr_offset = 3'd0;
    in_color    = 12'd0;
    @(negedge clk);
    n_vec++;
    if ({in_rtr, mem_en, mem_we, done, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 17'd0, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got rtr=%b en=%b we=%b done=%b addr=%h wdata=%h expected rtr=1 en=0 we=0 done=0 addr=0 wdata=0",
               in_rtr, mem_en, mem_we, done, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int t, dc;
    gnt_force = 1'b1;
    preload(0, 32'hFFFFFFFF);
    clear_log();
    send_cmd(0, 0, 12'hABC, t);
    wait_done(50, dc);
    ref_write(0, 0, 12'hABC);
    n_vec++;
    if (q_at(rd_cycles, 0) !== t + 1) begin
      n_err++;
      $display("[TB] FAIL single_read_cycle: got %0d expected %0d", q_at(rd_cycles, 0), t + 1);
    end
    n_vec++;
    if (q_at(wr_cycles, 0) !== t + 3) begin
      n_err++;
      $display("[TB] FAIL single_write_cycle: got %0d expected %0d", q_at(wr_cycles, 0), t + 3);
    end
    n_vec++;
    if (dc !== t + 4) begin
      n_err++;
      $display("[TB] FAIL single_done_cycle: got %0d expected %0d", dc, t + 4);
    end
    n_vec++;
    if (in_rtr !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL single_rtr_at_done: got %b expected 1", in_rtr);
    end
    n_vec++;
    if (mem[0] !== 32'hFFFFFABC) begin
      n_err++;
      $display("[TB] FAIL single_mem0: got %h expected FFFFFABC", mem[0]);
    end
    n_vec++;
    if (mem[0] !== ref_mem[0]) begin
      n_err++;
      $display("[TB] FAIL single_mem0_model: got %h expected %h", mem[0], ref_mem[0]);
    end
  endtask

  task automatic test_split_k2();
    int t, dc;
    gnt_force = 1'b1;
    preload(3, 32'h0);
    preload(4, 32'h0);
    preload(5, 32'h0);
    clear_log();
    send_cmd(3, 2, 12'h123, t);
    wait_done(50, dc);
    n_vec++;
    if ({mem[3], mem[4]} !== {32'h23000000, 32'h00000001}) begin
      n_err++;
      $display("[TB] FAIL k2_words: got %h %h expected 23000000 00000001", mem[3], mem[4]);
    end
    n_vec++;
    if (q_at(rd_cycles, 1) !== t + 4) begin
      n_err++;
      $display("[TB] FAIL k2_second_read: got %0d expected %0d", q_at(rd_cycles, 1), t + 4);
    end
    n_vec++;
    if (q_at(wr_cycles, 1) !== t + 6) begin
      n_err++;
      $display("[TB] FAIL k2_second_write: got %0d expected %0d", q_at(wr_cycles, 1), t + 6);
    end
    n_vec++;
    if (dc !== t + 7 || in_rtr !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL k2_done: got cycle %0d rtr %b expected cycle %0d rtr 1", dc, in_rtr, t + 7);
    end
    n_vec++;
    if (mem[5] !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL k2_word2_untouched: got %h expected 00000000", mem[5]);
    end
    ref_write(3, 2, 12'h123);
  endtask

  task automatic test_split_k5_k7();
    int t, dc;
    gnt_force = 1'b1;
    preload(6, 32'hFFFFFFFF);
    preload(7, 32'hFFFFFFFF);
    preload(8, 32'hFFFFFFFF);
    send_cmd(6, 5, 12'hFED, t);
    wait_done(50, dc);
    n_vec++;
    if ({mem[7], mem[8]} !== {32'hDFFFFFFF, 32'hFFFFFFFE}) begin
      n_err++;
      $display("[TB] FAIL k5_words: got %h %h expected DFFFFFFF FFFFFFFE", mem[7], mem[8]);
    end
    ref_write(6, 5, 12'hFED);
    preload(8, 32'h0);
    send_cmd(6, 7, 12'h5A5, t);
    wait_done(50, dc);
    n_vec++;
    if (mem[8] !== 32'h5A500000) begin
      n_err++;
      $display("[TB] FAIL k7_word: got %h expected 5A500000", mem[8]);
    end
    n_vec++;
    if (dc !== t + 4) begin
      n_err++;
      $display("[TB] FAIL k7_done_cycle: got %0d expected %0d", dc, t + 4);
    end
    ref_write(6, 7, 12'h5A5);
  endtask

  task automatic test_grant_stall();
    int t, dc;
    logic [11:0] c;
    logic [31:0] exp_w;
    logic pattern [1:8];
    pattern = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    c = 12'($urandom);
    preload(10, $urandom);
    preload(11, $urandom);
    preload(12, $urandom);
    ref_write(10, 0, c);
    exp_w = ref_mem[10];
    gnt_force = 1'b0;
    clear_log();
    send_cmd(10, 0, c, t);
    for (int off = 1; off <= 8; off++) begin
      gnt_force = pattern[off];
      n_vec++;
      if (in_rtr !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL stall_rtr_low: cycle +%0d got %b expected 0", off, in_rtr);
      end
      if (off <= 4) begin
        n_vec++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 17'd10}) begin
          n_err++;
          $display("[TB] FAIL stall_read_hold: cycle +%0d got en=%b we=%b addr=%h expected en=1 we=0 addr=0000a",
                   off, mem_en, mem_we, mem_addr);
        end
      end
      if (off >= 6) begin
        n_vec++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 17'd10, exp_w}) begin
          n_err++;
          $display("[TB] FAIL stall_write_hold: cycle +%0d got en=%b we=%b addr=%h wdata=%h expected en=1 we=1 addr=0000a wdata=%h",
                   off, mem_en, mem_we, mem_addr, mem_wdata, exp_w);
        end
      end
      @(negedge clk);
    end
    gnt_force = 1'b1;
    n_vec++;
    if (done !== 1'b1 || in_rtr !== 1'b1 || cyc !== t + 9) begin
      n_err++;
      $display("[TB] FAIL stall_done: got done=%b rtr=%b at cycle %0d expected done=1 rtr=1 at %0d",
               done, in_rtr, cyc, t + 9);
    end
    n_vec++;
    if (q_at(rd_cycles, 0) !== t + 4 || q_at(wr_cycles, 0) !== t + 8) begin
      n_err++;
      $display("[TB] FAIL stall_accept_cycles: got rd %0d wr %0d expected rd %0d wr %0d",
               q_at(rd_cycles, 0), q_at(wr_cycles, 0), t + 4, t + 8);
    end
    n_vec++;
    if (mem[10] !== exp_w) begin
      n_err++;
      $display("[TB] FAIL stall_mem: got %h expected %h", mem[10], exp_w);
    end
  endtask

  task automatic test_back_to_back();
    int ks [4];
    logic [11:0] cs [4];
    int n, dc;
    ks = '{0, 1, 3, 6};
    gnt_force = 1'b1;
    for (int i = 0; i < 3; i++) preload(i, 32'h0);
    @(negedge clk);
    in_rts = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cs[i]       = 12'($urandom);
      init_addr   = 17'd0;
      addr_offset = 3'(ks[i]);
      in_color    = cs[i];
      n = 0;
      while (!in_rtr && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) begin
        n_vec++;
        if (done !== 1'b1 || in_rtr !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL b2b_accept_on_done: cmd %0d got done=%b rtr=%b expected done=1 rtr=1", i, done, in_rtr);
        end
      end
      ref_write(0, ks[i], cs[i]);
      @(negedge clk);
    end
    in_rts = 1'b0;
    wait_done(50, dc);
    n_vec++;
    if (dc < 0) begin
      n_err++;
      $display("[TB] FAIL b2b_final_done: got timeout expected done pulse");
    end
    n_vec++;
    if ({mem[0], mem[1], mem[2]} !== {ref_mem[0], ref_mem[1], ref_mem[2]}) begin
      n_err++;
      $display("[TB] FAIL b2b_mem: got %h %h %h expected %h %h %h",
               mem[0], mem[1], mem[2], ref_mem[0], ref_mem[1], ref_mem[2]);
    end
  endtask

  task automatic test_reset_mid();
    int t, dc;
    logic [11:0] c;
    c = 12'($urandom);
    gnt_force = 1'b1;
    preload(3, $urandom);
    preload(4, $urandom);
    preload(5, $urandom);
    send_cmd(3, 2, c, t);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    n_vec++;
    if ({in_rtr, mem_en, mem_we, done, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 17'd0, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL midreset_outputs: got rtr=%b en=%b we=%b done=%b addr=%h wdata=%h expected rtr=1 en=0 we=0 done=0 addr=0 wdata=0",
               in_rtr, mem_en, mem_we, done, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({mem[3], mem[4]} !== {ref_mem[3], ref_mem[4]}) begin
      n_err++;
      $display("[TB] FAIL midreset_untouched: got %h %h expected %h %h", mem[3], mem[4], ref_mem[3], ref_mem[4]);
    end
    c = 12'($urandom);
    send_cmd(3, 2, c, t);
    wait_done(50, dc);
    ref_write(3, 2, c);
    n_vec++;
    if (dc !== t + 7 || {mem[3], mem[4]} !== {ref_mem[3], ref_mem[4]}) begin
      n_err++;
      $display("[TB] FAIL midreset_recover: got done %0d words %h %h expected done %0d words %h %h",
               dc, mem[3], mem[4], t + 7, ref_mem[3], ref_mem[4]);
    end
  endtask

  task automatic test_random();
    int t, dc, a, k;
    logic [11:0] c;
    int bad;
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    rand_gnt = 1'b1;
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 250);
      k = $urandom_range(0, 7);
      c = 12'($urandom);
      send_cmd(a, k, c, t);
      wait_done(200, dc);
      ref_write(a, k, c);
      n_vec++;
      if (dc < 0 || {mem[a], mem[a+1], mem[a+2]} !== {ref_mem[a], ref_mem[a+1], ref_mem[a+2]}) begin
        n_err++;
        $display("[TB] FAIL random_pixel: addr %0d k %0d got done %0d words %h %h %h expected %h %h %h",
                 a, k, dc, mem[a], mem[a+1], mem[a+2], ref_mem[a], ref_mem[a+1], ref_mem[a+2]);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL random_done_pulse: got %b expected 0", done);
      end
    end
    rand_gnt = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL random_full_memory: got %0d differing words expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_single_word();
    test_split_k2();
    test_split_k5_k7();
    test_grant_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pixel_write_engine.md
# pixel_write_engine

Framebuffer write stage that sits directly downstream of the addressing engine. Consumes one pixel command per handshake: 17-bit group word address, 3-bit pixel offset and 12-bit colour. Performs a read-modify-write of the one or two 32-bit framebuffer words holding that pixel, then releases the handshake for the next command. Framebuffer packing is 8 pixels × 12 bits = 96 bits = 3 consecutive 32-bit words per group.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_  in  1  reset; one clock; reset is asynchronous and active-low
- init_addr  in  17  word address of word 0 of the pixel group
- addr_offset  in  3  pixel index k within group (0–7)
- in_color  in  12  pixel colour
- in_rts  in  1  upstream has a command
- in_rtr  out  1  block accepts a command; transfer = in_rts & in_rtr
- mem_en  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_en
- mem_addr  out  17  request word address
- mem_wdata  out  32  write data
- mem_gnt  in  1  arbiter grant; request accepted when mem_en & mem_gnt
- mem_rdata  in  32  read data, valid exactly one cycle after an accepted read
- done  out  1  one-cycle pulse after final write of a pixel is accepted

## Operation
- Pixel k occupies bits [12k+11:12k] of the 96-bit group, word 0 = bits 31:0, word 1 = 63:32, word 2 = 95:64. Colour LSBs go to the lower word.
- Mapping:
  - k0: w0[11:0]
  - k1: w0[23:12]
  - k2: w0[31:24]=c[7:0], w1[3:0]=c[11:8]
  - k3: w1[15:4]
  - k4: w1[27:16]
  - k5: w1[31:28]=c[3:0], w2[7:0]=c[11:4]
  - k6: w2[19:8]
  - k7: w2[31:20]
- First word = init_addr + (k<3 ? 0 : k<6 ? 1 : 2), computed in 17 bits with no wrap check. Word count is 2 for k=2 and k=5, otherwise 1.
- Command fields are latched on transfer. Inputs are ignored at all other times.
- Unmodified bits of every word are written back exactly as read.
- States:
  - IDLE: in_rtr=1. On transfer → READ with word index 0.
  - READ: mem_en=1, mem_we=0, mem_addr = current word. On grant → WAIT.
  - WAIT: capture mem_rdata and merge the colour field → WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_addr unchanged, mem_wdata = merged word. On grant:
    - second word pending → READ at address+1;
    - otherwise → IDLE, done=1 in the following cycle.
- mem_en, mem_we, mem_addr and mem_wdata are registered and held stable while awaiting grant.
- in_rtr is 0 in every state except IDLE. No new command is accepted until done.

## Timing
- Reset values: state IDLE, in_rtr=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, internal latches 0.
- With mem_gnt held 1, transfer in cycle T:
  - READ accepted at T+1
  - data captured at T+2
  - WRITE accepted at T+3
  - in_rtr=1 and done=1 at T+4
- Two-word pixels: second read accepted at T+4, second write at T+6, in_rtr=1 and done=1 at T+7.
- Each cycle of mem_gnt=0 in READ or WRITE adds exactly one cycle. mem_rdata is sampled only in the cycle following read acceptance.
- A transfer in the cycle that done is high is legal. The next READ follows at the next cycle.
- Reset mid-operation (any state) returns to IDLE immediately. mem_en drops asynchronously and the pending pixel is discarded; partially written two-word pixels are not repaired.

## Test plan
- Single word, gnt=1: addr 0, k0, colour ABC, mem[0]=FFFFFFFF → read 0 at T+1, write mem[0]=FFFFFABC at T+3, done at T+4.
- Split k2: addr 3, colour 123, mem[3]=mem[4]=00000000 → mem[3]=23000000, mem[4]=00000001, done at T+7.
- Split k5 plus k7: addr 6, colour FED with mem[7]=mem[8]=FFFFFFFF → mem[7]=DFFFFFFF, mem[8]=FFFFFFFE. Then k7, colour 5A5 with mem[8]=00000000 → mem[8]=5A500000.
- Grant stall: k0 command with mem_gnt low 3 cycles in READ and 2 in WRITE → mem_en/mem_addr/mem_wdata stable throughout, done at T+9, in_rtr low until then.
- Back-to-back: in_rts held high with 4 commands k0,k1,k3,k6 on addr 0 of zeroed memory → each accepted the cycle done pulses. Final mem[0]=00ABC... per colours, with no lost or merged writes.
- Reset in WAIT of a k2 command → all outputs at reset values immediately, in_rtr=1, mem[4] untouched, next command processes normally.
